// File: rtl/dual_update_pkg.sv
// dual_update_pkg: shared types and arithmetic helpers for the horizon dual update
package dual_update_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  function automatic int step_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  // Sign-extended operands in, result clamped or wrapped to w bits (still sign-extended)
  function automatic longint sat_add(input longint a, input longint b, input int w, input bit sat_en);
    longint s, hi, lo;
    s = a + b;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    return sat_en ? (s > hi ? hi : s < lo ? lo : s) : (s <<< (64 - w)) >>> (64 - w);
  endfunction
  function automatic longint abs_diff(input longint a, input longint b);
    return a > b ? a - b : b - a;
  endfunction
endpackage

// File: rtl/dual_lane.sv
// dual_lane: one lane of the dual update; S1 registers a-b, S2 registers sat(dual + d)
module dual_lane import dual_update_pkg::*; #(
  parameter int W = 16,
  parameter int SAT_EN = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ld1,
  input  logic                ld2,
  input  logic                zero,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic signed [W-1:0] dual,
  output logic signed [W-1:0] out,
  output logic        [W:0]   mag
);
  logic signed [W:0]   d;
  logic signed [W-1:0] dual_r;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      d <= '0;
      dual_r <= '0;
      out <= '0;
    end else begin
      if (ld1) begin
        d <= zero ? '0 : (W+1)'(a) - (W+1)'(b);
        dual_r <= dual;
      end
      if (ld2) out <= W'(sat_add(longint'(dual_r), longint'(d), W, SAT_EN != 0));
    end
  assign mag = (W+1)'(abs_diff(longint'(d), longint'(0)));
endmodule

// File: rtl/dual_update_horizon.sv
// dual_update_horizon: streams N_HORIZON ADMM dual-update steps and tracks max primal residuals
module dual_update_horizon import dual_update_pkg::*; #(
  parameter int STATE_DIM = 12,
  parameter int CONTROL_DIM = 4,
  parameter int W = 16,
  parameter int N_HORIZON = 10,
  parameter int SAT_EN = 1,
  localparam int SW = step_w(N_HORIZON)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] x_k [STATE_DIM],
  input  logic signed [W-1:0] v_k [STATE_DIM],
  input  logic signed [W-1:0] g_k [STATE_DIM],
  input  logic signed [W-1:0] u_k [CONTROL_DIM],
  input  logic signed [W-1:0] z_k [CONTROL_DIM],
  input  logic signed [W-1:0] y_k [CONTROL_DIM],
  input  logic        [W:0]   tol_x,
  input  logic        [W:0]   tol_u,
  output logic                out_valid,
  input  logic                out_ready,
  output logic        [SW-1:0] out_step,
  output logic                ctrl_valid,
  output logic signed [W-1:0] y_out [CONTROL_DIM],
  output logic signed [W-1:0] g_out [STATE_DIM],
  output logic        [W:0]   res_x,
  output logic        [W:0]   res_u,
  output logic                converged,
  output logic                done
);
  localparam int CW = $clog2(N_HORIZON + 1);
  localparam logic [CW-1:0] N_C = CW'(N_HORIZON);
  state_t state, nxt;
  logic [CW-1:0] in_cnt, out_cnt;
  logic [W:0] tol_x_r, tol_u_r, max_x, max_u;
  logic [W:0] mag_x [STATE_DIM];
  logic [W:0] mag_u [CONTROL_DIM];
  logic v1, ctrl1, stall, in_fire, ld2, last_in;
  logic [SW-1:0] step1;
  assign stall = out_valid && !out_ready;
  assign in_ready = state == RUN && in_cnt < N_C && !stall;
  assign in_fire = in_valid && in_ready;
  assign ld2 = v1 && !stall;
  assign last_in = in_cnt == N_C - 1'b1;
  assign busy = state != IDLE;
  assign done = state == DONE;
  for (genvar i = 0; i < STATE_DIM; i++) begin : g_x
    dual_lane #(.W(W), .SAT_EN(SAT_EN)) lane (
      .clk(clk), .reset(reset), .ld1(in_fire), .ld2(ld2), .zero(1'b0),
      .a(x_k[i]), .b(v_k[i]), .dual(g_k[i]), .out(g_out[i]), .mag(mag_x[i])
    );
  end
  // The last step carries no control: its control lanes see d=0, passing y through and adding nothing to res_u
  for (genvar i = 0; i < CONTROL_DIM; i++) begin : g_u
    dual_lane #(.W(W), .SAT_EN(SAT_EN)) lane (
      .clk(clk), .reset(reset), .ld1(in_fire), .ld2(ld2), .zero(last_in),
      .a(u_k[i]), .b(z_k[i]), .dual(y_k[i]), .out(y_out[i]), .mag(mag_u[i])
    );
  end
  always_comb begin
    max_x = '0;
    max_u = '0;
    for (int j = 0; j < STATE_DIM; j++) max_x = mag_x[j] > max_x ? mag_x[j] : max_x;
    for (int j = 0; j < CONTROL_DIM; j++) max_u = mag_u[j] > max_u ? mag_u[j] : max_u;
    nxt = state == IDLE  ? (start ? RUN : IDLE) :
          state == RUN   ? (in_cnt == N_C ? DRAIN : RUN) :
          state == DRAIN ? (out_cnt == N_C ? DONE : DRAIN) : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      in_cnt <= '0;
      out_cnt <= '0;
      tol_x_r <= '0;
      tol_u_r <= '0;
      res_x <= '0;
      res_u <= '0;
      converged <= 1'b0;
      v1 <= 1'b0;
      ctrl1 <= 1'b0;
      step1 <= '0;
      out_valid <= 1'b0;
      ctrl_valid <= 1'b0;
      out_step <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        in_cnt <= '0;
        out_cnt <= '0;
        res_x <= '0;
        res_u <= '0;
        tol_x_r <= tol_x;
        tol_u_r <= tol_u;
        converged <= 1'b0;
      end else begin
        if (in_fire) in_cnt <= in_cnt + 1'b1;
        if (out_valid && out_ready) out_cnt <= out_cnt + 1'b1;
      end
      if (state == DRAIN && out_cnt == N_C) converged <= (res_x <= tol_x_r) && (res_u <= tol_u_r);
      if (!stall) begin
        v1 <= in_fire;
        out_valid <= v1;
      end
      if (in_fire) begin
        step1 <= in_cnt[SW-1:0];
        ctrl1 <= !last_in;
      end
      if (ld2) begin
        out_step <= step1;
        ctrl_valid <= ctrl1;
        res_x <= max_x > res_x ? max_x : res_x;
        res_u <= max_u > res_u ? max_u : res_u;
      end
    end
endmodule

// File: tb/tb_dual_update_horizon.sv
// tb_dual_update_horizon: directed checks on an N=2 saturating instance and an N=10 wrapping instance
module tb_dual_update_horizon;
  localparam int SD = 12, CD = 4, W = 16;
  logic clk = 0, reset = 1, st = 0, iv = 0, out_ready = 1, sel = 0;
  logic signed [W-1:0] x [SD], v [SD], g [SD], u [CD], z [CD], y [CD];
  logic [W:0] tol_x, tol_u;
  logic start_a, start_b, in_valid_a, in_valid_b;
  logic busy_a, in_ready_a, out_valid_a, ctrl_a, conv_a, done_a, busy_b, in_ready_b, out_valid_b, ctrl_b, conv_b, done_b;
  logic [0:0] step_a;
  logic [3:0] step_b;
  logic signed [W-1:0] y_a [CD], g_a [SD], y_b [CD], g_b [SD];
  logic [W:0] rx_a, ru_a, rx_b, ru_b;
  logic o_valid, o_ctrl, o_busy, o_rdy, o_done, o_conv;
  int o_step;
  logic signed [W-1:0] o_y [CD], o_g [SD];
  logic [W:0] o_rx, o_ru;
  int total = 0, bad = 0, cyc = 0, hs_cyc = 0;
  assign start_a = st && !sel;
  assign start_b = st && sel;
  assign in_valid_a = iv && !sel;
  assign in_valid_b = iv && sel;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  dual_update_horizon #(.N_HORIZON(2), .SAT_EN(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .x_k(x), .v_k(v), .g_k(g), .u_k(u), .z_k(z), .y_k(y), .tol_x(tol_x), .tol_u(tol_u),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_step(step_a), .ctrl_valid(ctrl_a),
    .y_out(y_a), .g_out(g_a), .res_x(rx_a), .res_u(ru_a), .converged(conv_a), .done(done_a)
  );
  dual_update_horizon #(.N_HORIZON(10), .SAT_EN(0)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .x_k(x), .v_k(v), .g_k(g), .u_k(u), .z_k(z), .y_k(y), .tol_x(tol_x), .tol_u(tol_u),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_step(step_b), .ctrl_valid(ctrl_b),
    .y_out(y_b), .g_out(g_b), .res_x(rx_b), .res_u(ru_b), .converged(conv_b), .done(done_b)
  );
  always_comb begin
    o_valid = sel ? out_valid_b : out_valid_a;
    o_ctrl = sel ? ctrl_b : ctrl_a;
    o_busy = sel ? busy_b : busy_a;
    o_rdy = sel ? in_ready_b : in_ready_a;
    o_done = sel ? done_b : done_a;
    o_conv = sel ? conv_b : conv_a;
    o_rx = sel ? rx_b : rx_a;
    o_ru = sel ? ru_b : ru_a;
    o_step = sel ? int'(step_b) : int'(step_a);
    for (int j = 0; j < CD; j++) o_y[j] = sel ? y_b[j] : y_a[j];
    for (int j = 0; j < SD; j++) o_g[j] = sel ? g_b[j] : g_a[j];
  end
  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  // Step k stimulus: u-z = 2j-3+k, x-v = 2j-11+k, y = 10k, g = k
  task automatic set_vec(input int k);
    for (int j = 0; j < CD; j++) begin
      u[j] = W'(j + 1 + k);
      z[j] = W'(4 - j);
      y[j] = W'(10 * k);
    end
    for (int j = 0; j < SD; j++) begin
      x[j] = W'(j + 1);
      v[j] = W'(12 - j - k);
      g[j] = W'(k);
    end
  endtask
  task automatic feed(input int n, input bit kvar, input bit sat, input int gaps);
    bit hs;
    for (int k = 0; k < n; k++) begin
      set_vec(kvar ? k : 0);
      if (sat && k == 0) begin
        y[0] = 16'sh7fff; u[0] = 16'sd1; z[0] = 16'sd0;
        g[0] = 16'sh8000; x[0] = 16'sd0; v[0] = 16'sd1;
      end
      iv = 1;
      hs = 0;
      for (int t = 0; t < 100 && !hs; t++) begin
        @(negedge clk); #1;
        hs = o_rdy;
        if (hs) hs_cyc = cyc;
        @(posedge clk);
      end
      if (!hs) chk("in_handshake_timeout", 0, 1);
      #1 iv = 0;
      if (gaps[k]) begin
        repeat (2) @(posedge clk);
        #1;
      end
    end
  endtask
  task automatic collect(input int n, input bit kvar, input bit bp);
    int got, t;
    bit stalled;
    logic signed [W-1:0] y0;
    got = 0; t = 0; stalled = 0;
    while (got < n && t < 300) begin
      @(negedge clk); t++;
      if (o_valid) begin
        int kk;
        bit last;
        kk = kvar ? got : 0;
        last = got == n - 1;
        chk("out_step", o_step, got);
        chk("ctrl_valid", o_ctrl, !last);
        for (int j = 0; j < CD; j++) chk("y_out", o_y[j], last ? 10 * kk : 11 * kk + 2 * j - 3);
        for (int j = 0; j < SD; j++) chk("g_out", o_g[j], 2 * kk + 2 * j - 11);
        if (bp && got == 3 && !stalled) begin
          stalled = 1;
          out_ready = 0;
          y0 = o_y[0];
          repeat (3) begin
            @(negedge clk);
            chk("stall_valid", o_valid, 1);
            chk("stall_step", o_step, 3);
            chk("stall_y_hold", o_y[0], y0);
            chk("stall_in_ready", o_rdy, 0);
          end
          out_ready = 1;
        end
        got++;
      end
    end
    chk("out_count", got, n);
  endtask
  task automatic wait_done(output int dc);
    dc = -1;
    for (int t = 0; t < 50 && dc < 0; t++) begin
      @(negedge clk);
      if (o_done) dc = cyc;
    end
  endtask
  task automatic pulse_start;
    @(posedge clk); #1 st = 1;
    @(posedge clk); #1 st = 0;
  endtask
  task automatic run(input int n, input bit kvar, input int gaps, input bit bp);
    int dc;
    pulse_start();
    chk("busy_after_start", o_busy, 1);
    fork
      feed(n, kvar, 0, gaps);
      collect(n, kvar, bp);
      begin
        if (kvar) begin
          repeat (5) @(posedge clk);
          #1 st = 1;
          @(posedge clk);
          #1 st = 0;
        end
      end
    join
    wait_done(dc);
    chk("done_latency", dc - hs_cyc, 4);
    chk("done_without_out_valid", o_valid, 0);
    @(negedge clk);
    chk("done_one_cycle", o_done, 0);
    chk("idle_after_done", o_busy, 0);
  endtask
  task automatic sat_run(input logic signed [63:0] ey, input logic signed [63:0] eg);
    pulse_start();
    fork
      feed(2, 0, 1, 0);
      begin
        for (int t = 0; t < 20 && !o_valid; t++) @(negedge clk);
        chk("sat_valid", o_valid, 1);
        chk("sat_y", o_y[0], ey);
        chk("sat_g", o_g[0], eg);
      end
    join
  endtask
  initial begin
    int dc;
    tol_x = 17'd11;
    tol_u = 17'd3;
    set_vec(0);
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_busy", o_busy, 0);
      chk("rst_out_valid", o_valid, 0);
      chk("rst_in_ready", o_rdy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_converged", o_conv, 0);
      chk("rst_res_x", o_rx, 0);
      chk("rst_y_out", o_y[0], 0);
      chk("rst_g_out", o_g[11], 0);
    end
    sel = 0;
    reset = 0;
    run(2, 0, 0, 0);
    chk("res_u", o_ru, 3);
    chk("res_x", o_rx, 11);
    chk("converged_pass", o_conv, 1);
    tol_x = 17'd10;
    run(2, 0, 0, 0);
    chk("res_x_rerun", o_rx, 11);
    chk("converged_fail", o_conv, 0);
    sat_run(32767, -32768);
    wait_done(dc);
    chk("sat_run_done", dc >= 0, 1);
    sel = 1;
    tol_x = 17'd20;
    tol_u = 17'd11;
    sat_run(-32768, 32767);
    reset = 1;
    #1;
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_out_valid", o_valid, 0);
    chk("mid_rst_y_out", o_y[0], 0);
    chk("mid_rst_g_out", o_g[0], 0);
    chk("mid_rst_step", o_step, 0);
    chk("mid_rst_res_u", o_ru, 0);
    @(posedge clk);
    #1 reset = 0;
    run(10, 1, 'h24, 1);
    chk("res_u_horizon", o_ru, 11);
    chk("res_x_horizon", o_rx, 20);
    chk("converged_horizon", o_conv, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dual_update_horizon.md
Name: dual_update_horizon

Overview:
- Streaming, parametrised successor to the single-step ADMM dual update. Processes a full MPC horizon of N timesteps per start.
- Per step: y_new = sat(y + u - z) on CONTROL_DIM lanes and g_new = sat(g + x - v) on STATE_DIM lanes.
- Accumulates max-abs primal residuals over the horizon and flags convergence against run-time tolerances.
- Sits between the primal/slack update stages and the dual buffers in the ADMM iteration loop.

Parameters:
- STATE_DIM, 12, state lanes per timestep
- CONTROL_DIM, 4, control lanes per timestep
- W, 16, signed two's-complement data width
- N_HORIZON, 10, timesteps per run (states N, controls N-1), >=2
- SAT_EN, 1, 1 = saturate to W bits; 0 = wrap (truncate)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins run when idle, ignored otherwise
- busy  out  1  high from accepted start until done
- in_valid  in  1  input step present
- in_ready  out  1  block accepts step
- x_k, v_k, g_k  in  [STATE_DIM] x W signed  state, state slack, state dual
- u_k, z_k, y_k  in  [CONTROL_DIM] x W signed  control, control slack, control dual
- tol_x, tol_u  in  W+1 unsigned  residual tolerances, sampled at start
- out_valid  out  1  result step present
- out_ready  in  1  downstream accepts result
- out_step  out  clog2(N_HORIZON)  timestep index of result
- ctrl_valid  out  1  y_out meaningful (step < N-1)
- y_out  out  [CONTROL_DIM] x W signed  updated control dual
- g_out  out  [STATE_DIM] x W signed  updated state dual
- res_x, res_u  out  W+1 unsigned  max |x-v|, max |u-z| over run
- converged  out  1  res_x<=tol_x && res_u<=tol_u, valid with done
- done  out  1  one-cycle pulse after last result handshake

Behaviour:
- Asynchronous reset while reset=1: all outputs, counters and pipeline registers 0; FSM to IDLE. Applies mid-run; partial results are discarded.
- FSM:
  - IDLE: start -> RUN. Clear in/out step counters and residuals; latch tolerances.
  - RUN: accept steps until N_HORIZON inputs taken, then -> DRAIN.
  - DRAIN: when the N_HORIZON-th output handshakes -> DONE.
  - DONE: pulse done for 1 cycle, update converged -> IDLE.
- in_ready = (state==RUN) && in_count<N_HORIZON && !stall. stall = out_valid && !out_ready.
- 2-stage pipeline:
  - S1: d = a - b in W+1 bits; register d, original dual, step index.
  - S2: s = dual + d in W+2 bits; sat/wrap to W; |d| into W+1 bits; register outputs.
- Latency: 2 cycles from input handshake to out_valid with no stall. Throughput: 1 step/cycle.
- Stall freezes both stages and holds all outputs stable. Bubbles propagate as out_valid=0.
- Saturation (SAT_EN=1): clamp to [-2^(W-1), 2^(W-1)-1]. With SAT_EN=0, take the low W bits.
- Last step (step N-1):
  - control inputs are ignored; y_out = y_k unchanged; ctrl_valid=0.
  - u/z are excluded from res_u.
- Residuals update in S2 on valid, as running max. res_x/res_u hold their value until the next start.
- converged holds until the next start. It is 0 after reset.
- start during busy is ignored. start together with reset: reset wins.
- done and out_valid never assert in the same cycle.

Decomposition:
- Package dual_update_pkg:
  - fsm state enum (IDLE, RUN, DRAIN, DONE)
  - sat_add function (operands, width, SAT_EN)
  - abs_diff function
  - step-index width constant
- Sub-module dual_lane: one lane (S1 diff, S2 add/sat/abs, stall enable). Instantiated STATE_DIM + CONTROL_DIM times via generate.

Test Plan:
- Single run, W=16, N=2:
  - stimulus, both steps: u=i+1, z=4-i, y=0, x=i+1, v=12-i, g=0; out_ready=1
  - step0: y_out=-3,-1,1,3 and g_out=-11,-9,...,9,11 (step1 g_out identical)
  - step1: ctrl_valid=0, y_out=y_k
  - res_u=3, res_x=11
  - done exactly 2 cycles after last output, i.e. 4 cycles after the last input handshake
- Saturation:
  - y=32767, u=1, z=0 -> 32767
  - g=-32768, x=0, v=1 -> -32768
  - SAT_EN=0 variant -> -32768 and 32767 respectively
- Backpressure: out_ready low for 3 cycles mid-run -> outputs stable, in_ready=0, no step lost or duplicated; out_step sequence 0..N-1.
- Convergence:
  - tol_u=3, tol_x=11 with the first stimulus -> converged=1
  - tol_x=10 -> converged=0
- Reset mid-run: assert reset at step 1 of N=10 -> all outputs 0, busy=0, FSM IDLE; subsequent start completes a clean run.
- start during busy ignored; in_valid gaps produce bubbles yet the correct N outputs follow.
